aes_mode_ctrl: RTL and testbench
================================

Name: aes_mode_ctrl

Overview:
- Parametrised block-mode controller that sits in front of the AES-128 encryption core.
- Collects word-serial plaintext over a valid/ready stream, drives one 128-bit block per core operation, and returns word-serial results.
- Supports ECB and CTR modes, configurable word width and counter width, and keeps a running block count.
- The core is external and is attached through a start/done port set.

Parameters:
- WORD_W, 32, stream word width. Legal values: 8, 16, 32, 64, 128. NW = 128/WORD_W words per block.
- CTR_W, 32, number of low counter bits incremented in CTR mode (1..128). Upper 128-CTR_W bits are static.
- CNT_W, 32, width of blk_count.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; asynchronous, active-high.
- key_load  in  1  pulse; latches key_in, iv_in and cfg_mode.
- cfg_mode  in  1  0 = ECB, 1 = CTR.
- key_in  in  128  AES key.
- iv_in  in  128  initial counter block (CTR only).
- key_err  out  1  1-cycle pulse: key_load was rejected.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid & in_ready.
- in_data  in  WORD_W  input word.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream ready.
- out_data  out  WORD_W  output word.
- core_start  out  1  1-cycle pulse; starts the core.
- core_key  out  128  latched key, held stable.
- core_block  out  128  block to encrypt; stable from core_start until core_done.
- core_done  in  1  1-cycle pulse; core_result valid in the same cycle.
- core_result  in  128  core ciphertext.
- busy  out  1  high in CORE and UNLOAD.
- blk_count  out  CNT_W  blocks completed since last key_load; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_data=0, core_start=0, core_key=0, core_block=0, key_err=0, busy=0, blk_count=0. Internal counter=0, state=IDLE.
- Word mapping: word i (i=0 first on the wire) occupies block bits [i*WORD_W +: WORD_W]. The same mapping applies to input, output and the 128-bit core buses.
- IDLE: in_ready=0. key_load moves the block to LOAD, latches key and mode, sets counter=iv_in and clears blk_count.
- LOAD: in_ready=1.
  - Each handshake stores the word at index widx and increments widx.
  - On the handshake of word NW-1, the next cycle enters CORE, pulses core_start, and sets in_ready=0.
- CORE: wait for core_done. Capture the result in the same cycle:
  - ECB: res = core_result.
  - CTR: res = core_result XOR collected block.
  - Next cycle: UNLOAD.
- UNLOAD: out_valid=1 and out_data=res word oidx.
  - out_data is held stable while out_ready=0.
  - On the handshake of word NW-1: blk_count++. In CTR mode, counter[CTR_W-1:0] += 1 modulo 2^CTR_W, with upper bits unchanged. Next cycle: LOAD with in_ready=1.
- core_block source: ECB uses the collected block; CTR uses the counter value at core_start.
- Latency:
  - Last input handshake at cycle t gives core_start at t+1.
  - core_done at cycle d gives first out_valid at d+1.
  - With in_valid and out_ready held high, a block costs NW + 1 + core latency + NW cycles.
- key_load is accepted only in IDLE, or in LOAD with widx=0. Otherwise it is ignored, key_err pulses the next cycle, and state is unchanged.
- key_load in LOAD with widx=0 re-latches key, iv and mode, and clears blk_count.
- core_done outside CORE is ignored.
- If core_done and key_load occur in the same cycle in CORE, core_done is honoured and key_load is rejected.
- in_valid while in_ready=0 has no effect; data is not sampled.
- Reset asserted mid-operation (any state): immediate return to reset values. Partial block, res and counter are discarded, and a new key_load is required.
- WORD_W=128: NW=1, widx/oidx are unused, and a block is one handshake each way.

Test Plan:
- ECB, WORD_W=32, key 000102030405060708090a0b0c0d0e0f, plaintext 00112233445566778899aabbccddeeff, core model latency 10 returning 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: core_block equals the plaintext. Output words are 0x70b4c55a, 0xd8cdb780, 0x6a7b0430, 0x69c4e0d8. blk_count=1.
- CTR, CTR_W=32, iv low word 0xFFFFFFFF, upper 96 bits 0xA5 pattern, three blocks.
  - Required: core_block low word reads FFFFFFFF, then 00000000, then 00000001, with upper bits unchanged.
  - Required: each output equals model result XOR plaintext.
- Back-pressure: out_ready toggled 1,0,0,1 per cycle during UNLOAD.
  - Required: out_data holds while stalled, no word is lost or duplicated, and in_ready stays 0 until the last output handshake.
- key_load mid-block: key_load after 2 of 4 words in LOAD.
  - Required: key_err pulses once and the block completes with the old key. Then key_load at widx=0 is accepted and blk_count=0.
- Reset mid-operation: assert reset during CORE.
  - Required: all outputs return to reset values asynchronously. A later core_done is ignored. After reset, in_ready=0 until key_load.
- WORD_W=8 and WORD_W=128 builds run the ECB vector.
  - Required: 16 words and 1 word per block respectively, with identical 128-bit results.

Source files
------------

// File: rtl/aes_mode_ctrl_if.sv
// Word-serial stream bundle for aes_mode_ctrl: plaintext in, result out.
// master drives in_valid/in_data/out_ready; slave (the controller) drives the rest.
interface aes_mode_ctrl_if #(
    parameter int WORD_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/aes_mode_ctrl.sv
// aes_mode_ctrl: ECB/CTR block-mode front end for an external AES-128 core.
// Ports: clk, reset (async, active-high); key_load/cfg_mode/key_in/iv_in
// configure the mode, key_err flags a rejected key_load; s carries the
// word-serial in/out streams; core_start/core_key/core_block go to the core,
// core_done/core_result come back; busy and blk_count report progress.
module aes_mode_ctrl #(
    parameter int WORD_W = 32,
    parameter int CTR_W  = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_load,
    input  logic             cfg_mode,
    input  logic [127:0]     key_in,
    input  logic [127:0]     iv_in,
    output logic             key_err,
    aes_mode_ctrl_if.slave   s,
    output logic             core_start,
    output logic [127:0]     core_key,
    output logic [127:0]     core_block,
    input  logic             core_done,
    input  logic [127:0]     core_result,
    output logic             busy,
    output logic [CNT_W-1:0] blk_count
);
    localparam int NW = 128 / WORD_W;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IW-1:0] LAST = IW'(NW - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CORE,
        UNLOAD
    } state_t;

    state_t            r_state;
    logic [127:0]      r_key;
    logic [127:0]      r_ctr;
    logic [127:0]      r_blk;
    logic [127:0]      r_res;
    logic [127:0]      r_core_block;
    logic              r_mode;
    logic [IW-1:0]     r_widx;
    logic [IW-1:0]     r_oidx;
    logic [CNT_W-1:0]  r_blk_count;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [WORD_W-1:0] r_out_data;
    logic              r_core_start;
    logic              r_key_err;
    logic              r_busy;

    logic              w_hs_in;
    logic              w_hs_out;
    logic              w_last_in;
    logic              w_last_out;
    logic              w_load_ok;
    logic              w_key_acc;
    logic              w_mode_eff;
    logic [IW-1:0]     w_oidx_nx;
    logic [6:0]        w_wofs;
    logic [6:0]        w_oofs;
    logic [127:0]      w_blk_next;
    logic [127:0]      w_res;
    logic [127:0]      w_ctr_inc;
    logic [127:0]      w_ctr_eff;

    always_comb begin
        w_hs_in    = s.in_valid & r_in_ready;
        w_hs_out   = s.out_ready & r_out_valid;
        w_last_in  = (r_widx == LAST);
        w_last_out = (r_oidx == LAST);
        // key changes only between blocks: idle, or before the first word
        w_load_ok  = (r_state == IDLE) ||
                     ((r_state == LOAD) && (r_widx == '0));
        w_key_acc  = key_load & w_load_ok;
        w_oidx_nx  = r_oidx + IW'(1);
        w_wofs     = 7'(int'(r_widx) * WORD_W);
        w_oofs     = 7'(int'(w_oidx_nx) * WORD_W);

        w_blk_next = r_blk;
        w_blk_next[w_wofs +: WORD_W] = s.in_data;

        w_res = r_mode ? (core_result ^ r_blk) : core_result;

        // only the low CTR_W bits count; the rest of the IV is static
        w_ctr_inc = r_ctr;
        w_ctr_inc[CTR_W-1:0] = r_ctr[CTR_W-1:0] + CTR_W'(1);

        // a key_load accepted alongside the only word (NW=1) applies at once
        w_mode_eff = w_key_acc ? cfg_mode : r_mode;
        w_ctr_eff  = w_key_acc ? iv_in : r_ctr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_key        <= '0;
            r_ctr        <= '0;
            r_blk        <= '0;
            r_res        <= '0;
            r_core_block <= '0;
            r_mode       <= 1'b0;
            r_widx       <= '0;
            r_oidx       <= '0;
            r_blk_count  <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_core_start <= 1'b0;
            r_key_err    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            r_key_err    <= key_load & ~w_load_ok;

            if (w_key_acc) begin
                r_key       <= key_in;
                r_mode      <= cfg_mode;
                r_ctr       <= iv_in;
                r_blk_count <= '0;
            end

            unique case (r_state)
                IDLE: begin
                    if (key_load) begin
                        r_state    <= LOAD;
                        r_in_ready <= 1'b1;
                        r_widx     <= '0;
                    end
                end
                LOAD: begin
                    if (w_hs_in) begin
                        r_blk <= w_blk_next;
                        if (w_last_in) begin
                            r_widx       <= '0;
                            r_state      <= CORE;
                            r_in_ready   <= 1'b0;
                            r_core_start <= 1'b1;
                            r_busy       <= 1'b1;
                            r_core_block <= w_mode_eff ? w_ctr_eff
                                                       : w_blk_next;
                        end else begin
                            r_widx <= r_widx + IW'(1);
                        end
                    end
                end
                CORE: begin
                    if (core_done) begin
                        r_res       <= w_res;
                        r_out_data  <= w_res[WORD_W-1:0];
                        r_out_valid <= 1'b1;
                        r_oidx      <= '0;
                        r_state     <= UNLOAD;
                    end
                end
                UNLOAD: begin
                    if (w_hs_out) begin
                        if (w_last_out) begin
                            r_out_valid <= 1'b0;
                            r_oidx      <= '0;
                            r_blk_count <= r_blk_count + CNT_W'(1);
                            if (r_mode) begin
                                r_ctr <= w_ctr_inc;
                            end
                            r_state    <= LOAD;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                        end else begin
                            r_oidx     <= w_oidx_nx;
                            r_out_data <= r_res[w_oofs +: WORD_W];
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign s.in_ready  = r_in_ready;
    assign s.out_valid = r_out_valid;
    assign s.out_data  = r_out_data;
    assign key_err     = r_key_err;
    assign core_start  = r_core_start;
    assign core_key    = r_key;
    assign core_block  = r_core_block;
    assign busy        = r_busy;
    assign blk_count   = r_blk_count;
endmodule

// File: tb/tb_aes_mode_ctrl.sv
// Directed bench for aes_mode_ctrl: 32-bit build for ECB/CTR/back-pressure/
// key_load/reset cases, plus 8-bit and 128-bit builds on the ECB vector.
module tb_aes_mode_ctrl;
    localparam logic [127:0] KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] MASK = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] IV   = 128'hA5A5A5A5A5A5A5A5A5A5A5A5FFFFFFFF;
    localparam logic [127:0] CB1  = 128'hA5A5A5A5A5A5A5A5A5A5A5A500000000;
    localparam logic [127:0] CB2  = 128'hA5A5A5A5A5A5A5A5A5A5A5A500000001;
    localparam logic [127:0] P1   = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] P2   = 128'hdeadbeef00000000cafebabe11111111;
    localparam logic [127:0] P3   = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         key_load = 1'b0;
    logic         cfg_mode = 1'b0;
    logic [127:0] key_in = '0;
    logic [127:0] iv_in = '0;
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           done_cyc = -100;
    logic [127:0] last_got = '0;

    always #5 clk = ~clk;

    // stand-in core: known AES vector for PT, a fixed scramble otherwise
    function automatic logic [127:0] f(input logic [127:0] b);
        return (b == PT) ? CT : ({b[63:0], b[127:64]} ^ MASK);
    endfunction

    aes_mode_ctrl_if #(.WORD_W(32)) i32 ();
    aes_mode_ctrl_if #(.WORD_W(8)) i8 ();
    aes_mode_ctrl_if #(.WORD_W(128)) i128 ();

    logic         ke32, cs32, bs32, d32 = 1'b0;
    logic [127:0] ck32, cb32, cr32 = '0;
    logic [31:0]  bc32;
    logic         ke8, cs8, bs8, d8 = 1'b0;
    logic [127:0] ck8, cb8, cr8 = '0;
    logic [31:0]  bc8;
    logic         ke128, cs128, bs128, d128 = 1'b0;
    logic [127:0] ck128, cb128, cr128 = '0;
    logic [31:0]  bc128;

    aes_mode_ctrl #(.WORD_W(32), .CTR_W(32), .CNT_W(32)) u32 (
        .clk(clk), .reset(reset), .key_load(key_load),
        .cfg_mode(cfg_mode), .key_in(key_in), .iv_in(iv_in),
        .key_err(ke32), .s(i32), .core_start(cs32), .core_key(ck32),
        .core_block(cb32), .core_done(d32), .core_result(cr32),
        .busy(bs32), .blk_count(bc32)
    );

    aes_mode_ctrl #(.WORD_W(8), .CTR_W(32), .CNT_W(32)) u8 (
        .clk(clk), .reset(reset), .key_load(key_load),
        .cfg_mode(cfg_mode), .key_in(key_in), .iv_in(iv_in),
        .key_err(ke8), .s(i8), .core_start(cs8), .core_key(ck8),
        .core_block(cb8), .core_done(d8), .core_result(cr8),
        .busy(bs8), .blk_count(bc8)
    );

    aes_mode_ctrl #(.WORD_W(128), .CTR_W(32), .CNT_W(32)) u128 (
        .clk(clk), .reset(reset), .key_load(key_load),
        .cfg_mode(cfg_mode), .key_in(key_in), .iv_in(iv_in),
        .key_err(ke128), .s(i128), .core_start(cs128), .core_key(ck128),
        .core_block(cb128), .core_done(d128), .core_result(cr128),
        .busy(bs128), .blk_count(bc128)
    );

    int n32 = 0, n8 = 0, n128 = 0;
    logic [127:0] b32 = '0, b8 = '0, b128 = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (d32) done_cyc <= cyc;
    end

    always @(posedge clk) begin
        d32 <= 1'b0;
        if (n32 > 0) begin
            n32 <= n32 - 1;
            if (n32 == 1) begin
                d32  <= 1'b1;
                cr32 <= f(b32);
            end
        end
        if (cs32) begin
            n32 <= LAT;
            b32 <= cb32;
        end
    end

    always @(posedge clk) begin
        d8 <= 1'b0;
        if (n8 > 0) begin
            n8 <= n8 - 1;
            if (n8 == 1) begin
                d8  <= 1'b1;
                cr8 <= f(b8);
            end
        end
        if (cs8) begin
            n8 <= LAT;
            b8 <= cb8;
        end
    end

    always @(posedge clk) begin
        d128 <= 1'b0;
        if (n128 > 0) begin
            n128 <= n128 - 1;
            if (n128 == 1) begin
                d128  <= 1'b1;
                cr128 <= f(b128);
            end
        end
        if (cs128) begin
            n128 <= LAT;
            b128 <= cb128;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic m, input logic [127:0] k,
                        input logic [127:0] iv);
        @(negedge clk);
        key_load = 1'b1;
        cfg_mode = m;
        key_in   = k;
        iv_in    = iv;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    task automatic send32(input logic [127:0] pt, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            @(negedge clk);
            i32.in_valid = 1'b1;
            i32.in_data  = pt[i*32 +: 32];
            for (int w = 0; w < 50 && !i32.in_ready; w++) @(negedge clk);
            chk("in_ready_wait", 128'(i32.in_ready), 128'(1));
            @(posedge clk);
        end
        @(negedge clk);
        i32.in_valid = 1'b0;
    endtask

    task automatic recv32(input bit bp, input logic [127:0] exp);
        logic [127:0] got;
        logic [31:0]  held;
        int           k, u;
        bit           first, stall;
        got = '0; held = '0; k = 0; u = 0; first = 1'b1; stall = 1'b0;
        for (int c = 0; c < 400 && k < 4; c++) begin
            @(negedge clk);
            if (i32.out_valid) begin
                if (stall) chk("hold", 128'(i32.out_data), 128'(held));
                if (first) begin
                    chk("out_latency", 128'(cyc), 128'(done_cyc + 1));
                    first = 1'b0;
                end
                chk("in_ready_unload", 128'(i32.in_ready), 128'(0));
                i32.out_ready = bp ? ((u % 4 == 0) || (u % 4 == 3)) : 1'b1;
                u++;
                stall = !i32.out_ready;
                held  = i32.out_data;
                if (i32.out_ready) begin
                    got[k*32 +: 32] = i32.out_data;
                    k++;
                end
            end
        end
        @(negedge clk);
        chk("out_words", 128'(k), 128'(4));
        chk("out_block", got, exp);
        chk("out_drained", 128'(i32.out_valid), 128'(0));
        chk("in_ready_back", 128'(i32.in_ready), 128'(1));
        last_got = got;
    endtask

    task automatic blk32(input logic [127:0] pt, input logic [127:0] cb,
                         input logic [127:0] exp, input bit bp);
        send32(pt, 0, 4);
        chk("core_start", 128'(cs32), 128'(1));
        chk("core_block", cb32, cb);
        chk("busy_core", 128'(bs32), 128'(1));
        chk("in_ready_core", 128'(i32.in_ready), 128'(0));
        recv32(bp, exp);
    endtask

    task automatic run8(input logic [127:0] pt);
        logic [127:0] got;
        int           k;
        got = '0; k = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            i8.in_valid = 1'b1;
            i8.in_data  = pt[i*8 +: 8];
            for (int w = 0; w < 50 && !i8.in_ready; w++) @(negedge clk);
            @(posedge clk);
        end
        @(negedge clk);
        i8.in_valid = 1'b0;
        chk("w8_start", 128'(cs8), 128'(1));
        chk("w8_block", cb8, PT);
        i8.out_ready = 1'b1;
        for (int c = 0; c < 200 && k < 16; c++) begin
            @(negedge clk);
            if (i8.out_valid) begin
                got[k*8 +: 8] = i8.out_data;
                k++;
            end
        end
        @(negedge clk);
        chk("w8_words", 128'(k), 128'(16));
        chk("w8_result", got, CT);
        chk("w8_count", 128'(bc8), 128'(1));
        chk("w8_idle", 128'({i8.out_valid, bs8, ke8}), 128'(0));
        chk("w8_key", ck8, KEY);
    endtask

    task automatic run128(input logic [127:0] pt);
        logic [127:0] got;
        int           k;
        got = '0; k = 0;
        @(negedge clk);
        i128.in_valid = 1'b1;
        i128.in_data  = pt;
        for (int w = 0; w < 50 && !i128.in_ready; w++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        i128.in_valid = 1'b0;
        chk("w128_start", 128'(cs128), 128'(1));
        chk("w128_block", cb128, PT);
        i128.out_ready = 1'b1;
        for (int c = 0; c < 200 && k < 1; c++) begin
            @(negedge clk);
            if (i128.out_valid) begin
                got = i128.out_data;
                k++;
            end
        end
        @(negedge clk);
        chk("w128_words", 128'(k), 128'(1));
        chk("w128_result", got, CT);
        chk("w128_count", 128'(bc128), 128'(1));
        chk("w128_idle", 128'({i128.out_valid, bs128, ke128}), 128'(0));
        chk("w128_key", ck128, KEY);
    endtask

    initial begin
        i32.in_valid = 1'b0;  i32.in_data = '0;  i32.out_ready = 1'b0;
        i8.in_valid = 1'b0;   i8.in_data = '0;   i8.out_ready = 1'b0;
        i128.in_valid = 1'b0; i128.in_data = '0; i128.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(i32.in_ready), 128'(0));
        chk("rst_out", 128'({i32.out_valid, i32.out_data}), 128'(0));
        chk("rst_core", 128'({cs32, ke32, bs32}), 128'(0));
        chk("rst_key", ck32, 128'(0));
        chk("rst_block", cb32, 128'(0));
        chk("rst_count", 128'(bc32), 128'(0));
        reset = 1'b0;

        // still idle without a key_load
        repeat (2) @(negedge clk);
        chk("idle_in_ready", 128'(i32.in_ready), 128'(0));

        // ECB known-answer block
        load(1'b0, KEY, 128'(0));
        chk("load_in_ready", 128'(i32.in_ready), 128'(1));
        chk("load_key", ck32, KEY);
        chk("load_err", 128'(ke32), 128'(0));
        blk32(PT, PT, CT, 1'b0);
        chk("ecb_w0", 128'(last_got[31:0]), 128'(32'h70b4c55a));
        chk("ecb_w1", 128'(last_got[63:32]), 128'(32'hd8cdb780));
        chk("ecb_w2", 128'(last_got[95:64]), 128'(32'h6a7b0430));
        chk("ecb_w3", 128'(last_got[127:96]), 128'(32'h69c4e0d8));
        chk("ecb_count", 128'(bc32), 128'(1));

        // CTR with low-word wrap; second block under back-pressure
        load(1'b1, KEY2, IV);
        chk("ctr_err", 128'(ke32), 128'(0));
        chk("ctr_count0", 128'(bc32), 128'(0));
        blk32(P1, IV, f(IV) ^ P1, 1'b0);
        blk32(P2, CB1, f(CB1) ^ P2, 1'b1);
        blk32(P3, CB2, f(CB2) ^ P3, 1'b0);
        chk("ctr_count3", 128'(bc32), 128'(3));

        // key_load mid-block is rejected and the block completes
        load(1'b0, KEY, 128'(0));
        chk("mid_pre_count", 128'(bc32), 128'(0));
        send32(PT, 0, 2);
        load(1'b0, KEY2, 128'(0));
        chk("mid_err_pulse", 128'(ke32), 128'(1));
        chk("mid_key_kept", ck32, KEY);
        @(negedge clk);
        chk("mid_err_once", 128'(ke32), 128'(0));
        send32(PT, 2, 4);
        chk("mid_core_start", 128'(cs32), 128'(1));
        chk("mid_core_block", cb32, PT);
        recv32(1'b0, CT);
        chk("mid_count", 128'(bc32), 128'(1));
        chk("mid_key_after", ck32, KEY);
        load(1'b0, KEY2, 128'(0));
        chk("w0_err", 128'(ke32), 128'(0));
        chk("w0_key", ck32, KEY2);
        chk("w0_count", 128'(bc32), 128'(0));

        // reset while the core is working
        send32(PT, 0, 4);
        chk("pre_rst_busy", 128'(bs32), 128'(1));
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 128'(bs32), 128'(0));
        chk("arst_in_ready", 128'(i32.in_ready), 128'(0));
        chk("arst_block", cb32, 128'(0));
        chk("arst_key", ck32, 128'(0));
        chk("arst_count", 128'(bc32), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        i32.out_ready = 1'b1;
        repeat (15) @(negedge clk);
        chk("late_done_out", 128'({i32.out_valid, bs32}), 128'(0));
        chk("late_in_ready", 128'(i32.in_ready), 128'(0));

        // narrow and full-width builds on the ECB vector
        load(1'b0, KEY, 128'(0));
        run8(PT);
        run128(PT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
